rand_class_gen: RTL and testbench
=================================

# rand_class_gen

Synthesizable, parametrised random-number source that produces raw, odd, even or one-hot words from a 32-bit Galois LFSR. Outputs use a valid/ready handshake. It replaces behavioural `$random` stimulus blocks wherever a bench or on-chip test-pattern path needs repeatable, seedable, class-constrained random values. It sits between a control/CSR block (seed, mode, enable) and any consumer that accepts `out_data`.

## Interface
Parameters:
- `WIDTH`, 8: output word width; legal range 2..32.
- `SEED`, 32'h0000_0001: LFSR value after reset; also substituted for a zero seed load. Must be nonzero.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: generation enable.
- `mode`, input, 2: 0 raw, 1 odd, 2 even, 3 one-hot.
- `seed_load`, input, 1: one-cycle pulse that loads `seed_in` into the LFSR.
- `seed_in`, input, 32: seed value.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: consumer accepts the word.
- `out_data`, output, WIDTH: generated word.
- `out_mode`, output, 2: mode that was used to build `out_data`.

## Operation
- LFSR step: `s_next = s[0] ? (s >> 1) ^ 32'h8020_0003 : s >> 1`. Polynomial is x^32+x^22+x^2+x+1.
- Candidate word is built from `s_next`. Let `r = s_next[WIDTH-1:0]`.
  - raw: `r`
  - odd: `r | 1`
  - even: `r & ~1`
  - one-hot: `1 << idx`, where `idx = s_next[IDXW-1:0]` and `IDXW = $clog2(WIDTH)`.
- One-hot rejection: if `idx >= WIDTH` (only possible when WIDTH is not a power of two), the candidate is discarded and the block steps again. There is no modulo bias.
- FSM states:
  - IDLE: `out_valid` = 0. Goes to GEN when `en` = 1.
  - GEN: steps the LFSR and samples `mode`. Goes to HOLD with the registered word, or stays in GEN on a one-hot rejection. Returns to IDLE if `en` = 0.
  - HOLD: `out_valid` = 1; `out_data` and `out_mode` are stable. On `out_ready` = 1, goes to GEN if `en` = 1, else IDLE. `en` falling while in HOLD does not drop `out_valid`; the held word is still delivered.
- `seed_load`:
  - Takes priority over every state transition. In its cycle the LFSR gets `seed_in`, or `SEED` if `seed_in` = 0.
  - Any held word is discarded (`out_valid` goes 0 next cycle), and the state goes to IDLE.
  - Generation resumes normally the following cycle if `en` = 1.
- `mode` changes take effect only at the next GEN cycle; a held word never changes.
- The LFSR state can never become 0.

## Timing
- Reset values:
  - LFSR = `SEED`
  - state = IDLE
  - `out_valid` = 0
  - `out_data` = 0
  - `out_mode` = 0
  - statistics counters = 0
- Latency: with `en` = 1 asserted in cycle N (state IDLE), the state is GEN in N+1 and `out_valid` = 1 in N+2. Each one-hot rejection adds one cycle.
- Throughput: one word per 2 cycles while `out_ready` is held high (HOLD→GEN→HOLD).
- A transfer occurs on the edge where `out_valid` && `out_ready`. `out_ready` is ignored while `out_valid` = 0.
- `rst` asserted at any point, including mid-HOLD, immediately clears `out_valid` with no clock needed. The sequence restarts from `SEED`.

## Configuration
- `RAND_CLASS_GEN_STATS_EN` defined: adds two saturating 16-bit outputs.
  - `stat_words`: count of accepted transfers.
  - `stat_rejects`: count of one-hot rejections.
  - Both clear on `rst` and on `seed_load`.
- Not defined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan
- Reset, WIDTH=8, SEED=1, mode=0, `en`=1, `out_ready`=1 → `out_valid` first high 2 cycles after `en`. Words are 8'h03 then 8'h02 (LFSR 32'h8020_0003, then 32'hC030_0002).
- Same setup, one run per mode:
  - mode=1 → first word 8'h03
  - mode=2 → first word 8'h02
  - mode=3 → first word 8'h08, second word 8'h04
- Backpressure: `out_ready`=0 for 10 cycles while in HOLD → `out_data` and `out_mode` stay stable and `out_valid` stays 1. Toggling `mode` meanwhile does not change the word. `out_ready`=1 → one transfer, and the next word appears 2 cycles later.
- `seed_load` with `seed_in`=0 during HOLD → `out_valid` 0 next cycle. The sequence then repeats the SEED=1 words (8'h03, 8'h02).
- WIDTH=12, mode=3, 1000 words → each word has exactly one bit set, in bits [11:0]. Reference-model rejection cycles match. With STATS_EN defined, `stat_rejects` equals the model's count and `stat_words`=1000.
- `rst` pulsed asynchronously mid-HOLD → `out_valid` low before the next edge. After release, the word sequence restarts from the reset values.

Source files
------------

// File: rtl/rand_class_gen.sv
// rand_class_gen: seedable, class-constrained random word source (raw / odd / even / one-hot).
// Latency: en in cycle N (IDLE) -> GEN in N+1 -> out_valid in N+2; each one-hot reject adds a cycle.
// Backpressure: word held stable in HOLD until out_ready; one word per 2 cycles at full rate.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   en                     generation enable
//   mode[1:0]              0 raw, 1 odd, 2 even, 3 one-hot (sampled in GEN only)
//   seed_load, seed_in     one-cycle pulse loading seed_in (zero seed replaced by SEED)
//   out_valid/out_ready    valid/ready handshake for out_data
//   out_data[WIDTH-1:0]    generated word
//   out_mode[1:0]          mode that built out_data
//   stat_words/stat_rejects  saturating 16-bit counters, present only when
//                          RAND_CLASS_GEN_STATS_EN is defined
//
// Optional feature macro: RAND_CLASS_GEN_STATS_EN (undefined by default).

`default_nettype none

module rand_class_gen #(
   parameter int          WIDTH = 8,                // legal range 2..32
   parameter logic [31:0] SEED  = 32'h0000_0001     // must be nonzero
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             seed_load,
   input  logic [31:0]      seed_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       out_mode
`ifdef RAND_CLASS_GEN_STATS_EN
   ,
   output logic [15:0]      stat_words,
   output logic [15:0]      stat_rejects
`endif
);

   localparam int              IDXW      = $clog2(WIDTH);
   // Galois taps for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0]     TAPS      = 32'h8020_0003;
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   // WIDTH always fits in IDXW+1 bits because WIDTH <= 2**IDXW
   localparam logic [IDXW:0]   WIDTH_IDX = (IDXW+1)'(WIDTH);

   localparam logic [1:0] MODE_RAW    = 2'd0;
   localparam logic [1:0] MODE_ODD    = 2'd1;
   localparam logic [1:0] MODE_EVEN   = 2'd2;
   localparam logic [1:0] MODE_ONEHOT = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GEN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic [31:0]       lfsr_q,      lfsr_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [1:0]        out_mode_q,  out_mode_d;

`ifdef RAND_CLASS_GEN_STATS_EN
   logic [15:0]       stat_words_q,   stat_words_d;
   logic [15:0]       stat_rejects_q, stat_rejects_d;
`endif

   logic [31:0]       lfsr_step;
   logic [WIDTH-1:0]  raw_word;
   logic [IDXW-1:0]   onehot_idx;
   logic              onehot_reject;
   logic [WIDTH-1:0]  cand_word;
   logic [31:0]       seed_eff;

   // ------------------------------------------------------------------
   // Candidate word construction from the next LFSR value
   // ------------------------------------------------------------------
   always_comb begin
      // A nonzero state always steps to a nonzero state: when bit 0 is set
      // the XOR forces bit 31 high, otherwise the shift keeps a set bit.
      lfsr_step  = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
      raw_word   = lfsr_step[WIDTH-1:0];
      onehot_idx = lfsr_step[IDXW-1:0];

      // Out-of-range index is rejected rather than folded, so one-hot
      // positions stay uniformly distributed for non-power-of-two WIDTH.
      onehot_reject = (mode == MODE_ONEHOT) && ({1'b0, onehot_idx} >= WIDTH_IDX);

      cand_word = raw_word;
      case (mode)
         MODE_RAW:    cand_word = raw_word;
         MODE_ODD:    cand_word = raw_word | ONE;
         MODE_EVEN:   cand_word = raw_word & ~ONE;
         MODE_ONEHOT: cand_word = ONE << onehot_idx;
         default:     cand_word = raw_word;
      endcase

      // A zero seed would lock the LFSR, so substitute the reset seed.
      seed_eff = (seed_in == 32'd0) ? SEED : seed_in;
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_mode_d  = out_mode_q;
`ifdef RAND_CLASS_GEN_STATS_EN
      stat_words_d   = stat_words_q;
      stat_rejects_d = stat_rejects_q;
`endif

      if (seed_load) begin
         // Reseed wins over any transition and drops a pending word.
         lfsr_d      = seed_eff;
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
`ifdef RAND_CLASS_GEN_STATS_EN
         stat_words_d   = 16'd0;
         stat_rejects_d = 16'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en) begin
                  state_d = ST_GEN;
               end
            end

            ST_GEN: begin
               if (!en) begin
                  state_d = ST_IDLE;
               end else begin
                  lfsr_d = lfsr_step;
                  if (onehot_reject) begin
                     // Stay in GEN and draw again on the next cycle.
`ifdef RAND_CLASS_GEN_STATS_EN
                     if (stat_rejects_q != 16'hFFFF) begin
                        stat_rejects_d = stat_rejects_q + 16'd1;
                     end
`endif
                  end else begin
                     out_data_d  = cand_word;
                     out_mode_d  = mode;
                     out_valid_d = 1'b1;
                     state_d     = ST_HOLD;
                  end
               end
            end

            ST_HOLD: begin
               // en falling here does not withdraw the word already offered.
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = en ? ST_GEN : ST_IDLE;
`ifdef RAND_CLASS_GEN_STATS_EN
                  if (stat_words_q != 16'hFFFF) begin
                     stat_words_d = stat_words_q + 16'd1;
                  end
`endif
               end
            end

            default: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lfsr_q      <= SEED;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mode_q  <= 2'd0;
`ifdef RAND_CLASS_GEN_STATS_EN
         stat_words_q   <= 16'd0;
         stat_rejects_q <= 16'd0;
`endif
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mode_q  <= out_mode_d;
`ifdef RAND_CLASS_GEN_STATS_EN
         stat_words_q   <= stat_words_d;
         stat_rejects_q <= stat_rejects_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mode  = out_mode_q;
`ifdef RAND_CLASS_GEN_STATS_EN
   assign stat_words   = stat_words_q;
   assign stat_rejects = stat_rejects_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rand_class_gen.sv
// Bench for rand_class_gen: WIDTH=8 instance for directed sequences,
// WIDTH=12 instance for the one-hot rejection run.
// Expected words/modes/gaps are queued when stimulus is applied and popped on transfer.

`timescale 1ns/1ps

module tb_rand_class_gen;

   localparam logic [31:0] SEED_V = 32'h0000_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic        seed_load;
   logic [31:0] seed_in;

   logic        en8, rdy8, v8;
   logic [1:0]  mode8, om8;
   logic [7:0]  d8;

   logic        en12, rdy12, v12;
   logic [1:0]  mode12, om12;
   logic [11:0] d12;

`ifdef RAND_CLASS_GEN_STATS_EN
   logic [15:0] sw8, sr8, sw12, sr12;
`endif

   int n_checks = 0;
   int n_err    = 0;

   logic [31:0] model_lfsr;
   logic [31:0] exp_data[$];
   logic [1:0]  exp_mode[$];
   int          exp_gap[$];
   int          rej12;
   int          rej_tmp;

   always #5 clk = ~clk;

   rand_class_gen #(.WIDTH(8), .SEED(SEED_V)) u8 (
      .clk(clk), .rst(rst), .en(en8), .mode(mode8),
      .seed_load(seed_load), .seed_in(seed_in),
      .out_valid(v8), .out_ready(rdy8), .out_data(d8), .out_mode(om8)
`ifdef RAND_CLASS_GEN_STATS_EN
      , .stat_words(sw8), .stat_rejects(sr8)
`endif
   );

   rand_class_gen #(.WIDTH(12), .SEED(SEED_V)) u12 (
      .clk(clk), .rst(rst), .en(en12), .mode(mode12),
      .seed_load(seed_load), .seed_in(seed_in),
      .out_valid(v12), .out_ready(rdy12), .out_data(d12), .out_mode(om12)
`ifdef RAND_CLASS_GEN_STATS_EN
      , .stat_words(sw12), .stat_rejects(sr12)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic push_c(input logic [31:0] d, input logic [1:0] md, input int gap);
      exp_data.push_back(d);
      exp_mode.push_back(md);
      exp_gap.push_back(gap);
   endtask

   // Reference model: advances model_lfsr and queues n words for a width-w generator.
   task automatic push_model(input int n, input logic [1:0] md, input int w, output int rej);
      logic [31:0] mask, raw, word;
      int idx, r;
      bit again;
      rej = 0;
      mask = (32'd1 << w) - 32'd1;
      for (int k = 0; k < n; k++) begin
         r = 0;
         do begin
            model_lfsr = lfsr_next(model_lfsr);
            idx   = int'(model_lfsr & ((32'd1 << $clog2(w)) - 32'd1));
            again = (md == 2'd3) && (idx >= w);
            if (again) r++;
         end while (again);
         raw = model_lfsr & mask;
         case (md)
            2'd0:    word = raw;
            2'd1:    word = raw | 32'd1;
            2'd2:    word = raw & ~32'd1;
            default: word = 32'd1 << idx;
         endcase
         push_c(word, md, 2 + r);
         rej += r;
      end
   endtask

   // Accept n words from one instance, checking each against the queue.
   // Called at a negedge (cycle 0 = the point where enable/restart was applied).
   task automatic drain(input bit w12, input int n, input bit gap_chk);
      int got, cyc, last, eg;
      logic [31:0] od, em;
      logic [1:0]  om, emd;
      got = 0; cyc = 0; last = 0;
      while (got < n && cyc < 40 * n + 40) begin
         @(negedge clk);
         cyc++;
         if (w12 ? (v12 && rdy12) : (v8 && rdy8)) begin
            od = w12 ? 32'(d12) : 32'(d8);
            om = w12 ? om12 : om8;
            if (exp_data.size() > 0) begin
               em  = exp_data.pop_front();
               emd = exp_mode.pop_front();
               eg  = exp_gap.pop_front();
            end else begin
               em = 32'hFFFF_FFFF; emd = 2'bxx; eg = -1;
            end
            chk("data", od, em);
            chk("out_mode", 32'(om), 32'(emd));
            if (gap_chk) chk("gap_cycles", 32'(cyc - last), 32'(eg));
            if (w12) chk("onehot", 32'($countones(od)), 32'd1);
            last = cyc;
            got++;
         end
      end
      chk("drain_count", 32'(got), 32'(n));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid8(input int budget);
      int c;
      c = 0;
      while (!v8 && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("wait_valid", 32'(v8), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      en8 = 1'b0; en12 = 1'b0; rdy8 = 1'b0; rdy12 = 1'b0; seed_load = 1'b0;
      exp_data.delete(); exp_mode.delete(); exp_gap.delete();
      @(negedge clk);
      rst = 1'b0;
      model_lfsr = SEED_V;
   endtask

   initial begin
      rst = 1'b1; seed_load = 1'b0; seed_in = 32'd0;
      en8 = 1'b0; rdy8 = 1'b0; mode8 = 2'd0;
      en12 = 1'b0; rdy12 = 1'b0; mode12 = 2'd3;

      // Reset state
      @(negedge clk);
      chk("rst_valid", 32'(v8), 32'd0);
      chk("rst_data", 32'(d8), 32'd0);
      chk("rst_mode", 32'(om8), 32'd0);
      chk("rst_valid12", 32'(v12), 32'd0);
`ifdef RAND_CLASS_GEN_STATS_EN
      chk("rst_stat_words", 32'(sw8), 32'd0);
      chk("rst_stat_rejects", 32'(sr8), 32'd0);
`endif

      // One run per mode from SEED=1; first gap 2 is the en->valid latency
      for (int md = 0; md < 4; md++) begin
         do_reset();
         mode8 = 2'(md);
         rdy8  = 1'b1;
         en8   = 1'b1;
         case (md)
            0: begin push_c(32'h03, 2'd0, 2); push_c(32'h02, 2'd0, 2); end
            1: begin push_c(32'h03, 2'd1, 2); push_c(32'h03, 2'd1, 2); end
            2: begin push_c(32'h02, 2'd2, 2); push_c(32'h02, 2'd2, 2); end
            default: begin push_c(32'h08, 2'd3, 2); push_c(32'h04, 2'd3, 2); end
         endcase
         drain(1'b0, 2, 1'b1);
      end

      // Backpressure: hold 10 cycles while toggling mode
      do_reset();
      mode8 = 2'd0; rdy8 = 1'b0; en8 = 1'b1;
      wait_valid8(10);
      for (int i = 0; i < 10; i++) begin
         mode8 = mode8 + 2'd1;
         @(negedge clk);
         chk("bp_valid", 32'(v8), 32'd1);
         chk("bp_data", 32'(d8), 32'h03);
         chk("bp_mode", 32'(om8), 32'd0);
      end
      mode8 = 2'd0; rdy8 = 1'b1;
      @(negedge clk);
      chk("bp_after_xfer_valid", 32'(v8), 32'd0);
      @(negedge clk);
      chk("bp_next_valid", 32'(v8), 32'd1);
      chk("bp_next_data", 32'(d8), 32'h02);
      rdy8 = 1'b0;

      // seed_load of zero during HOLD: word dropped, sequence restarts from SEED
      seed_load = 1'b1; seed_in = 32'd0;
      @(negedge clk);
      seed_load = 1'b0;
      chk("seed0_drop_valid", 32'(v8), 32'd0);
      rdy8 = 1'b1;
      push_c(32'h03, 2'd0, 2); push_c(32'h02, 2'd0, 2);
      drain(1'b0, 2, 1'b1);

      // Asynchronous reset in the middle of HOLD
      rdy8 = 1'b0;
      wait_valid8(10);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(v8), 32'd0);
      chk("async_rst_data", 32'(d8), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_lfsr = SEED_V;
      rdy8 = 1'b1;
      push_c(32'h03, 2'd0, 2); push_c(32'h02, 2'd0, 2);
      drain(1'b0, 2, 1'b1);

      // Nonzero seed, even mode, model-predicted words
      @(negedge clk);
      seed_load = 1'b1; seed_in = 32'h1234_5678;
      @(negedge clk);
      seed_load = 1'b0;
      mode8 = 2'd2;
      model_lfsr = 32'h1234_5678;
      push_model(4, 2'd2, 8, rej_tmp);
      drain(1'b0, 4, 1'b1);
      en8 = 1'b0;

      // WIDTH=12 one-hot: 1000 words, rejection cycles reflected in gaps
      do_reset();
      rdy12 = 1'b1; en12 = 1'b1;
      push_model(1000, 2'd3, 12, rej12);
      drain(1'b1, 1000, 1'b1);
      en12 = 1'b0;
      @(negedge clk);
      @(negedge clk);
`ifdef RAND_CLASS_GEN_STATS_EN
      chk("stat_words12", 32'(sw12), 32'd1000);
      chk("stat_rejects12", 32'(sr12), 32'(rej12));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
